sysid_read_master: RTL



---
 rtl/sysid_read_master_if.sv | 25 ++
 rtl/sysid_read_master.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/sysid_read_master_if.sv
// Avalon-MM read-only bus between the system-ID check master and the ID peripheral.
// Only the address LSB is carried: word 0 is the ID, word 1 the build timestamp.
interface sysid_read_master_if;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata,
    input  avm_readdatavalid
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata,
    output avm_readdatavalid
  );
endinterface

// File: rtl/sysid_read_master.sv
// Boot-time sanity check: reads the system ID and build timestamp over Avalon-MM
// and reports whether each matches the build-time constant, with a per-read timeout.
//
// state     | meaning
// S_IDLE    | waiting for start_i; results held
// S_ID_REQ  | read of word 0 presented, waiting for accept
// S_ID_WAIT | word 0 accepted, waiting for readdatavalid
// S_TS_REQ  | read of word 1 presented, waiting for accept
// S_TS_WAIT | word 1 accepted, waiting for readdatavalid
// S_DONE    | done pulse, flags valid
module sysid_read_master #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1617494454,
  parameter bit          USE_READDATAVALID  = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES     = 255
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  sysid_read_master_if.master        avm,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       id_ok_o,
  output logic                       ts_ok_o,
  output logic                       timeout_o,
  output logic [31:0]                sysid_value_o,
  output logic [31:0]                timestamp_value_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_ID_REQ, S_ID_WAIT, S_TS_REQ, S_TS_WAIT, S_DONE
  } state_e;

  localparam logic [15:0] CNT_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q;
  logic        read_q, addr_q, busy_q, done_q;
  logic        id_ok_q, ts_ok_q, timeout_q;
  logic [31:0] sysid_q, ts_q;
  logic [15:0] cnt_q, cnt_d;
  logic        accept, limit_hit;

  assign accept    = read_q & ~avm.avm_waitrequest;
  assign limit_hit = (cnt_q == CNT_LIMIT);
  assign cnt_d     = cnt_q + 16'd1;

  // An accept at the limit only counts as completion when the data comes with it;
  // a pipelined slave that still owes data at the limit has run out of budget.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      read_q    <= 1'b0;
      addr_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      id_ok_q   <= 1'b0;
      ts_ok_q   <= 1'b0;
      timeout_q <= 1'b0;
      sysid_q   <= '0;
      ts_q      <= '0;
      cnt_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q   <= S_ID_REQ;
            busy_q    <= 1'b1;
            read_q    <= 1'b1;
            addr_q    <= 1'b0;
            cnt_q     <= '0;
            id_ok_q   <= 1'b0;
            ts_ok_q   <= 1'b0;
            timeout_q <= 1'b0;
            sysid_q   <= '0;
            ts_q      <= '0;
          end
        end
        S_ID_REQ, S_TS_REQ: begin
          if (accept && !USE_READDATAVALID) begin
            if (state_q == S_ID_REQ) begin
              sysid_q <= avm.avm_readdata;
              state_q <= S_TS_REQ;
              addr_q  <= 1'b1;
              cnt_q   <= '0;
            end else begin
              ts_q    <= avm.avm_readdata;
              id_ok_q <= (sysid_q == EXPECTED_ID);
              ts_ok_q <= (avm.avm_readdata == EXPECTED_TIMESTAMP);
              state_q <= S_DONE;
              read_q  <= 1'b0;
              addr_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else if (limit_hit) begin
            state_q   <= S_DONE;
            read_q    <= 1'b0;
            addr_q    <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
          end else if (accept) begin
            state_q <= (state_q == S_ID_REQ) ? S_ID_WAIT : S_TS_WAIT;
            read_q  <= 1'b0;
            addr_q  <= 1'b0;
            cnt_q   <= cnt_d;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_ID_WAIT, S_TS_WAIT: begin
          if (avm.avm_readdatavalid) begin
            if (state_q == S_ID_WAIT) begin
              sysid_q <= avm.avm_readdata;
              state_q <= S_TS_REQ;
              read_q  <= 1'b1;
              addr_q  <= 1'b1;
              cnt_q   <= '0;
            end else begin
              ts_q    <= avm.avm_readdata;
              id_ok_q <= (sysid_q == EXPECTED_ID);
              ts_ok_q <= (avm.avm_readdata == EXPECTED_TIMESTAMP);
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end else if (limit_hit) begin
            state_q   <= S_DONE;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          read_q  <= 1'b0;
          addr_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign avm.avm_read      = read_q;
  assign avm.avm_address   = addr_q;
  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign id_ok_o           = id_ok_q;
  assign ts_ok_o           = ts_ok_q;
  assign timeout_o         = timeout_q;
  assign sysid_value_o     = sysid_q;
  assign timestamp_value_o = ts_q;

endmodule
